// File: rtl/pdm_capture_sequencer_if.sv
// PCM ingress and FIFO read-side bundle of the PDM capture sequencer.
// Latency: none (wires only).
// Backpressure: none; overflow is reported by the sequencer, not by this bundle.
interface pdm_capture_sequencer_if #(
  parameter int PCM_W = 16
);
  logic             pcm_valid_l;
  logic [PCM_W-1:0] pcm_l;
  logic             pcm_valid_r;
  logic [PCM_W-1:0] pcm_r;
  logic             fifo_pop;
  logic [PCM_W:0]   fifo_data;
  logic [3:0]       fifo_level;
  logic             fifo_empty;

  // Driver side: CIC outputs and register-interface reader
  modport master (
    output pcm_valid_l, pcm_l, pcm_valid_r, pcm_r, fifo_pop,
    input  fifo_data, fifo_level, fifo_empty
  );

  // Sequencer side
  modport slave (
    input  pcm_valid_l, pcm_l, pcm_valid_r, pcm_r, fifo_pop,
    output fifo_data, fifo_level, fifo_empty
  );
endinterface

// File: rtl/pdm_capture_sequencer.sv
// PDM mic clock/strobe generator with settle discard and tagged first-word-fall-through sample FIFO.
// Latency: pdm_clk and strobes registered (1 cycle); FIFO push visible on fifo_level/fifo_data 1 cycle later.
// Backpressure: none upstream; push into a full FIFO (without pop) drops the word and sets sticky overflow.
module pdm_capture_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int PCM_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [7:0]                   period,
  input  logic                         stereo,
  input  logic [3:0]                   settle_count,
  input  logic [2:0]                   threshold,
  input  logic                         overflow_clr,
  pdm_capture_sequencer_if.slave       bus,
  output logic                         pdm_clk,
  output logic                         bit_strobe_l,
  output logic                         bit_strobe_r,
  output logic                         irq,
  output logic                         overflow,
  output logic [1:0]                   state
);

  localparam int         AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0] LEVEL_FULL = 4'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RUN    = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     phase, per_q;
  logic [3:0]     cnt;
  logic           clk_nxt;
  logic           start_ok;

  logic [PCM_W:0] mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [3:0]     level;
  logic           full, empty;
  logic           push_en, both_vld, do_push, do_pop, ovf_set;
  logic [PCM_W:0] push_dat;

  assign start_ok = enable && (period >= 8'd2);
  assign state    = state_q;

  // Clock high for the first floor(per_q/2) phases of each period; never in IDLE
  assign clk_nxt = (state_q != S_IDLE) && (phase < {1'b0, per_q[7:1]});

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: STOP only leaves at the last phase so the clock ends on a full low half
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) state_d = (settle_count != 4'd0) ? S_SETTLE : S_RUN;
      end
      S_SETTLE: begin
        if (!enable)                                 state_d = S_STOP;
        else if (bus.pcm_valid_l && (cnt == 4'd1))   state_d = S_RUN;
      end
      S_RUN: begin
        if (!enable) state_d = S_STOP;
      end
      S_STOP: begin
        if (phase == per_q - 8'd1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Phase counter, latched config, settle counter, registered clock and edge strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      phase        <= '0;
      per_q        <= '0;
      cnt          <= '0;
      pdm_clk      <= 1'b0;
      bit_strobe_l <= 1'b0;
      bit_strobe_r <= 1'b0;
    end else begin
      pdm_clk      <= clk_nxt;
      bit_strobe_l <= (state_d != S_IDLE) && pdm_clk && !clk_nxt;
      bit_strobe_r <= (state_d != S_IDLE) && stereo && !pdm_clk && clk_nxt;
      if (state_q == S_IDLE) begin
        phase <= '0;
        if (start_ok) begin
          per_q <= period;
          cnt   <= settle_count;
        end
      end else begin
        phase <= (phase == per_q - 8'd1) ? 8'd0 : phase + 8'd1;
        if ((state_q == S_SETTLE) && enable && bus.pcm_valid_l && (cnt != 4'd0))
          cnt <= cnt - 4'd1;
      end
    end
  end

  // Ingress selection: left wins a same-cycle collision, right is only taken in stereo
  assign push_en  = (state_q == S_RUN) && (bus.pcm_valid_l || (stereo && bus.pcm_valid_r));
  assign both_vld = (state_q == S_RUN) && bus.pcm_valid_l && bus.pcm_valid_r && stereo;
  assign push_dat = bus.pcm_valid_l ? {1'b0, bus.pcm_l} : {1'b1, bus.pcm_r};

  assign full     = (level == LEVEL_FULL);
  assign empty    = (level == 4'd0);
  assign do_pop   = bus.fifo_pop && !empty;
  assign do_push  = push_en && (!full || do_pop);
  assign ovf_set  = both_vld || (push_en && !do_push);

  // FIFO storage and pointers; contents persist across IDLE/STOP
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      level <= level + {3'b000, do_push} - {3'b000, do_pop};
    end
  end

  // Sticky overflow; a set in the same cycle beats the clear
  always_ff @(posedge clk) begin
    if (rst)               overflow <= 1'b0;
    else if (ovf_set)      overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

  assign bus.fifo_data  = mem[rd_ptr];
  assign bus.fifo_level = level;
  assign bus.fifo_empty = empty;
  assign irq            = (threshold != 3'd0) && (level >= {1'b0, threshold});

endmodule
